// File: rtl/video_mnist_param_ctrl_pkg.sv
// video_mnist_param_ctrl_pkg: register map, core id, FSM states and control/status bit indices.
package video_mnist_param_ctrl_pkg;
  localparam logic [31:0] CORE_ID = 32'h527A_0101;
  localparam logic [7:0] ADR_CORE_ID = 8'h00;
  localparam logic [7:0] ADR_CONTROL = 8'h01;
  localparam logic [7:0] ADR_STATUS = 8'h02;
  localparam logic [7:0] ADR_FRAME_COUNT = 8'h03;
  localparam logic [7:0] ADR_SHADOW_TH = 8'h08;
  localparam logic [7:0] ADR_SHADOW_INV = 8'h09;
  localparam logic [7:0] ADR_SHADOW_BLANK = 8'h0A;
  localparam logic [7:0] ADR_ACTIVE_TH = 8'h0C;
  localparam logic [7:0] ADR_ACTIVE_INV = 8'h0D;
  localparam logic [7:0] ADR_ACTIVE_BLANK = 8'h0E;
  localparam logic [7:0] ADR_RESULT_NUMBER = 8'h10;
  localparam logic [7:0] ADR_RESULT_COUNT = 8'h11;
  localparam int CTRL_UPDATE_REQ = 0;
  localparam int CTRL_FORCE_IDLE = 1;
  localparam int STAT_PENDING = 0;
  localparam int STAT_IN_FRAME = 1;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;
endpackage

// File: rtl/video_mnist_frame_monitor.sv
// video_mnist_frame_monitor: tracks lines/frames on the input tap, flags end-of-frame and video idle.
module video_mnist_frame_monitor #(
  parameter int IMG_Y_NUM = 480,
  parameter int IMG_Y_WIDTH = 12,
  parameter int IDLE_TIMEOUT = 1023,
  parameter int TIMEOUT_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_sof,
  input  logic        in_tlast,
  input  logic        in_tvalid,
  input  logic        in_tready,
  output logic        in_frame,
  output logic        eof,
  output logic        idle,
  output logic [31:0] frame_cnt
);
  localparam logic [IMG_Y_WIDTH-1:0] LAST_LINE = IMG_Y_WIDTH'(IMG_Y_NUM - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT = TIMEOUT_WIDTH'(IDLE_TIMEOUT);
  logic beat;
  logic [IMG_Y_WIDTH-1:0] line_cnt, line_base;
  logic [TIMEOUT_WIDTH-1:0] idle_cnt;
  assign beat = in_tvalid & in_tready;
  // a frame start restarts the line count, which also discards an aborted frame
  assign line_base = in_sof ? '0 : line_cnt;
  assign eof = beat & in_tlast & (in_frame | in_sof) & (line_base == LAST_LINE);
  assign idle = idle_cnt == TIMEOUT;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      in_frame <= 1'b0;
      line_cnt <= '0;
      idle_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      if (beat) begin
        in_frame <= eof ? 1'b0 : in_frame | in_sof;
        line_cnt <= eof ? '0 : line_base + IMG_Y_WIDTH'(in_tlast);
      end
      frame_cnt <= frame_cnt + 32'(eof);
      idle_cnt <= beat ? '0 : idle_cnt + TIMEOUT_WIDTH'(!idle);
    end
endmodule

// File: rtl/video_mnist_param_ctrl.sv
// video_mnist_param_ctrl: Wishbone shadow params committed to the datapath only at EOF or when video is idle.
// Result latch is built only when VIDEO_MNIST_PARAM_CTRL_RESULT_EN is defined.
module video_mnist_param_ctrl
  import video_mnist_param_ctrl_pkg::*;
#(
  parameter int WB_ADR_WIDTH = 8,
  parameter int WB_DAT_WIDTH = 32,
  parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
  parameter int TUSER_WIDTH = 1,
  parameter int IMG_Y_NUM = 480,
  parameter int IMG_Y_WIDTH = 12,
  parameter int IDLE_TIMEOUT = 1023,
  parameter int TIMEOUT_WIDTH = 10,
  parameter logic [7:0] INIT_PARAM_TH = 8'd127,
  parameter logic INIT_PARAM_INV = 1'b0,
  parameter logic [7:0] INIT_BLANK_NUM = 8'd3,
  parameter int M_TNUMBER_WIDTH = 4,
  parameter int M_TCOUNT_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WB_ADR_WIDTH-1:0]    s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]    s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]    s_wb_dat_o,
  input  logic                       s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0]    s_wb_sel_i,
  input  logic                       s_wb_stb_i,
  output logic                       s_wb_ack_o,
  input  logic [TUSER_WIDTH-1:0]     mon_in_tuser,
  input  logic                       mon_in_tlast,
  input  logic                       mon_in_tvalid,
  input  logic                       mon_in_tready,
  input  logic [TUSER_WIDTH-1:0]     mon_out_tuser,
  input  logic [M_TNUMBER_WIDTH-1:0] mon_out_tnumber,
  input  logic [M_TCOUNT_WIDTH-1:0]  mon_out_tcount,
  input  logic                       mon_out_tvalid,
  input  logic                       mon_out_tready,
  output logic [7:0]                 param_th,
  output logic                       param_inv,
  output logic [7:0]                 param_blank_num
);
  state_t state, state_next;
  logic [7:0] adr, shadow_th, shadow_blank;
  logic shadow_inv, update_req, force_en, wr, ctrl_req, commit_go, in_frame, eof, idle;
  logic [31:0] frame_cnt;
  logic [WB_DAT_WIDTH-1:0] result_number_rd, result_count_rd;
  assign adr = 8'(s_wb_adr_i);
  assign s_wb_ack_o = s_wb_stb_i;
  assign wr = s_wb_stb_i & s_wb_we_i & s_wb_sel_i[0];
  assign ctrl_req = wr & (adr == ADR_CONTROL) & s_wb_dat_i[CTRL_UPDATE_REQ];
  assign commit_go = eof | (idle & force_en & !in_frame);

  video_mnist_frame_monitor #(
    .IMG_Y_NUM(IMG_Y_NUM),
    .IMG_Y_WIDTH(IMG_Y_WIDTH),
    .IDLE_TIMEOUT(IDLE_TIMEOUT),
    .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
  ) u_mon (
    .clk(clk),
    .reset(reset),
    .in_sof(mon_in_tuser[0]),
    .in_tlast(mon_in_tlast),
    .in_tvalid(mon_in_tvalid),
    .in_tready(mon_in_tready),
    .in_frame(in_frame),
    .eof(eof),
    .idle(idle),
    .frame_cnt(frame_cnt)
  );

  // a fresh update request landing in the COMMIT cycle re-arms straight to PENDING
  always_comb
    state_next = state == ST_IDLE ? (update_req ? ST_PENDING : ST_IDLE)
               : state == ST_PENDING ? (commit_go ? ST_COMMIT : ST_PENDING)
               : (ctrl_req ? ST_PENDING : ST_IDLE);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      update_req <= 1'b0;
      force_en <= 1'b0;
      shadow_th <= INIT_PARAM_TH;
      shadow_inv <= INIT_PARAM_INV;
      shadow_blank <= INIT_BLANK_NUM;
      param_th <= INIT_PARAM_TH;
      param_inv <= INIT_PARAM_INV;
      param_blank_num <= INIT_BLANK_NUM;
    end else begin
      state <= state_next;
      update_req <= ctrl_req | (update_req & (state != ST_COMMIT));
      if (wr & (adr == ADR_CONTROL)) force_en <= s_wb_dat_i[CTRL_FORCE_IDLE];
      if (wr & (adr == ADR_SHADOW_TH)) shadow_th <= s_wb_dat_i[7:0];
      if (wr & (adr == ADR_SHADOW_INV)) shadow_inv <= s_wb_dat_i[0];
      if (wr & (adr == ADR_SHADOW_BLANK)) shadow_blank <= s_wb_dat_i[7:0];
      if (state == ST_COMMIT) begin
        param_th <= shadow_th;
        param_inv <= shadow_inv;
        param_blank_num <= shadow_blank;
      end
    end

`ifdef VIDEO_MNIST_PARAM_CTRL_RESULT_EN
  logic [M_TNUMBER_WIDTH-1:0] result_number;
  logic [M_TCOUNT_WIDTH-1:0] result_count;
  logic unused_bits;
  assign unused_bits = ^{s_wb_dat_i, s_wb_sel_i, mon_in_tuser, mon_out_tuser};
  assign result_number_rd = WB_DAT_WIDTH'(result_number);
  assign result_count_rd = WB_DAT_WIDTH'(result_count);
  // only the frame-start beat carries the frame's first result
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      result_number <= '0;
      result_count <= '0;
    end else if (mon_out_tvalid & mon_out_tready & mon_out_tuser[0]) begin
      result_number <= mon_out_tnumber;
      result_count <= mon_out_tcount;
    end
`else
  logic unused_bits;
  assign unused_bits = ^{s_wb_dat_i, s_wb_sel_i, mon_in_tuser, mon_out_tuser, mon_out_tnumber,
                         mon_out_tcount, mon_out_tvalid, mon_out_tready};
  assign result_number_rd = '0;
  assign result_count_rd = '0;
`endif

  always_comb begin
    s_wb_dat_o = '0;
    case (adr)
      ADR_CORE_ID:       s_wb_dat_o = WB_DAT_WIDTH'(CORE_ID);
      ADR_CONTROL:       s_wb_dat_o = WB_DAT_WIDTH'({force_en, update_req});
      ADR_STATUS:        s_wb_dat_o = WB_DAT_WIDTH'({in_frame, update_req});
      ADR_FRAME_COUNT:   s_wb_dat_o = WB_DAT_WIDTH'(frame_cnt);
      ADR_SHADOW_TH:     s_wb_dat_o = WB_DAT_WIDTH'(shadow_th);
      ADR_SHADOW_INV:    s_wb_dat_o = WB_DAT_WIDTH'(shadow_inv);
      ADR_SHADOW_BLANK:  s_wb_dat_o = WB_DAT_WIDTH'(shadow_blank);
      ADR_ACTIVE_TH:     s_wb_dat_o = WB_DAT_WIDTH'(param_th);
      ADR_ACTIVE_INV:    s_wb_dat_o = WB_DAT_WIDTH'(param_inv);
      ADR_ACTIVE_BLANK:  s_wb_dat_o = WB_DAT_WIDTH'(param_blank_num);
      ADR_RESULT_NUMBER: s_wb_dat_o = result_number_rd;
      ADR_RESULT_COUNT:  s_wb_dat_o = result_count_rd;
      default: ;
    endcase
  end
endmodule
